// File: rtl/smm_sched_pkg.sv
// smm_sched_pkg: shared types and constants for the SMM job scheduler.
//   - beat kind encodings carried on req_kind
//   - scheduler FSM state enum
//   - entry / result field widths
//   - onehot2(): per-requester one-hot from a 1-bit index
package smm_sched_pkg;

    localparam int ROW_W     = 5;
    localparam int VAL_W     = 4;
    localparam int OUT_VAL_W = 9;

    typedef enum logic [1:0] {
        KIND_SIZE = 2'd0,
        KIND_A    = 2'd1,
        KIND_B    = 2'd2,
        KIND_RSV  = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/smm_sched_if.sv
// smm_sched_if: all non-clock signals of the scheduler.
//   req_*     : two requester beat streams (index = requester)
//   smm_in_*  : size / A / B beats replayed to the SMM
//   smm_out_* : SMM result stream
//   rsp_*     : results routed back, rsp_done job-complete pulse
//   err, busy, owner : status
// master = requester/SMM side, slave = scheduler.
interface smm_sched_if;
    import smm_sched_pkg::*;

    logic [1:0]                 req_valid;
    logic [1:0]                 req_ready;
    logic [1:0][1:0]            req_kind;
    logic [1:0]                 req_last;
    logic [1:0]                 req_size;
    logic [1:0][ROW_W-1:0]      req_row;
    logic [1:0][ROW_W-1:0]      req_col;
    logic [1:0][VAL_W-1:0]      req_val;

    logic                       smm_in_valid_size;
    logic                       smm_in_size;
    logic                       smm_in_valid_a;
    logic [ROW_W-1:0]           smm_in_row_a;
    logic [ROW_W-1:0]           smm_in_col_a;
    logic [VAL_W-1:0]           smm_in_val_a;
    logic                       smm_in_valid_b;
    logic [ROW_W-1:0]           smm_in_row_b;
    logic [ROW_W-1:0]           smm_in_col_b;
    logic [VAL_W-1:0]           smm_in_val_b;

    logic                       smm_out_valid;
    logic [ROW_W-1:0]           smm_out_row;
    logic [ROW_W-1:0]           smm_out_col;
    logic [OUT_VAL_W-1:0]       smm_out_val;

    logic [1:0]                 rsp_valid;
    logic [ROW_W-1:0]           rsp_row;
    logic [ROW_W-1:0]           rsp_col;
    logic [OUT_VAL_W-1:0]       rsp_val;
    logic [1:0]                 rsp_done;
    logic [1:0]                 err;
    logic                       busy;
    logic                       owner;

    modport master (
        output req_valid, req_kind, req_last, req_size, req_row, req_col, req_val,
        output smm_out_valid, smm_out_row, smm_out_col, smm_out_val,
        input  req_ready,
        input  smm_in_valid_size, smm_in_size,
        input  smm_in_valid_a, smm_in_row_a, smm_in_col_a, smm_in_val_a,
        input  smm_in_valid_b, smm_in_row_b, smm_in_col_b, smm_in_val_b,
        input  rsp_valid, rsp_row, rsp_col, rsp_val, rsp_done, err, busy, owner
    );

    modport slave (
        input  req_valid, req_kind, req_last, req_size, req_row, req_col, req_val,
        input  smm_out_valid, smm_out_row, smm_out_col, smm_out_val,
        output req_ready,
        output smm_in_valid_size, smm_in_size,
        output smm_in_valid_a, smm_in_row_a, smm_in_col_a, smm_in_val_a,
        output smm_in_valid_b, smm_in_row_b, smm_in_col_b, smm_in_val_b,
        output rsp_valid, rsp_row, rsp_col, rsp_val, rsp_done, err, busy, owner
    );

endinterface

// File: rtl/smm_rr_arb2.sv
// smm_rr_arb2: 2-way round-robin arbiter, purely combinational.
//   req[1:0] : requests
//   rr       : index that has priority when both request
//   gnt[1:0] : one-hot grant (zero when nobody requests)
//   win      : winner index (only meaningful when gnt != 0)
module smm_rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr,
    output logic [1:0] gnt,
    output logic       win
);
    assign win = req[rr] ? rr : ~rr;
    assign gnt = req & (win ? 2'b10 : 2'b01);
endmodule

// File: rtl/smm_sched.sv
// smm_sched: job scheduler for the sparse matrix multiplier.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : smm_sched_if.slave (requester beats, SMM in/out, responses, status)
// One job at a time: IDLE arbitrates a SIZE beat, LOAD replays A/B beats of the
// owner to the SMM, WAIT routes results back and ends on the first gap after a
// result or on timeout with no result at all. SMM and rsp outputs are registered.
module smm_sched
    import smm_sched_pkg::*;
#(
    parameter int TIMEOUT = 4096,
    parameter int TCNT_W  = 13
) (
    input  logic        clk,
    input  logic        rst,
    smm_sched_if.slave  bus
);
    localparam logic [TCNT_W-1:0] TLAST = TCNT_W'(TIMEOUT - 1);

    state_e            state, state_nx;
    logic              rr, owner, seen_b, got;
    logic [TCNT_W-1:0] tcnt;
    logic [1:0]        gnt, rdy, err_nx;
    logic              win, sel, hs, done;
    logic              size_nx, a_nx, b_nx;
    kind_e             kind;

    smm_rr_arb2 u_arb (.req(bus.req_valid), .rr(rr), .gnt(gnt), .win(win));

    // Requester whose beat is being looked at this cycle.
    assign sel  = (state == ST_IDLE) ? win : owner;
    assign kind = kind_e'(bus.req_kind[sel]);

    assign bus.req_ready = rdy;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.owner     = owner;

    // State register plus job bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            rr     <= 1'b0;
            owner  <= 1'b0;
            seen_b <= 1'b0;
            got    <= 1'b0;
            tcnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && hs) begin
                if (kind == KIND_SIZE) begin
                    owner  <= win;
                    seen_b <= 1'b0;
                end else begin
                    rr <= ~win;
                end
            end
            if (b_nx) seen_b <= 1'b1;
            if (state == ST_LOAD && state_nx == ST_WAIT) begin
                tcnt <= '0;
                got  <= 1'b0;
            end
            if (state == ST_WAIT) begin
                if (tcnt != TLAST) tcnt <= tcnt + 1'b1;
                if (bus.smm_out_valid) got <= 1'b1;
            end
            if (done) rr <= ~owner;
        end
    end

    // Next state.
    always_comb begin
        state_nx = state;
        done     = 1'b0;
        case (state)
            ST_IDLE: if (hs && kind == KIND_SIZE) state_nx = ST_LOAD;
            ST_LOAD: if (hs && kind == KIND_B && bus.req_last[owner]) state_nx = ST_WAIT;
            ST_WAIT: begin
                // A result beat at the timeout edge still counts as a result.
                done = !bus.smm_out_valid && (got || tcnt == TLAST);
                if (done) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Ready, handshake and next values of the registered pulses.
    always_comb begin
        rdy     = '0;
        err_nx  = '0;
        size_nx = 1'b0;
        a_nx    = 1'b0;
        b_nx    = 1'b0;
        case (state)
            ST_IDLE: rdy = gnt;
            ST_LOAD: rdy[owner] = 1'b1;
            default: ;
        endcase
        if (rst) rdy = '0;
        hs = bus.req_valid[sel] & rdy[sel];
        if (hs) begin
            case (state)
                ST_IDLE: begin
                    if (kind == KIND_SIZE) size_nx = 1'b1;
                    else                   err_nx[sel] = 1'b1;
                end
                ST_LOAD: begin
                    if (kind == KIND_A && !seen_b) a_nx = 1'b1;
                    else if (kind == KIND_B)       b_nx = 1'b1;
                    else                           err_nx[sel] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Registered SMM-side and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.smm_in_valid_size <= 1'b0;
            bus.smm_in_size       <= 1'b0;
            bus.smm_in_valid_a    <= 1'b0;
            bus.smm_in_row_a      <= '0;
            bus.smm_in_col_a      <= '0;
            bus.smm_in_val_a      <= '0;
            bus.smm_in_valid_b    <= 1'b0;
            bus.smm_in_row_b      <= '0;
            bus.smm_in_col_b      <= '0;
            bus.smm_in_val_b      <= '0;
            bus.rsp_valid         <= '0;
            bus.rsp_row           <= '0;
            bus.rsp_col           <= '0;
            bus.rsp_val           <= '0;
            bus.rsp_done          <= '0;
            bus.err               <= '0;
        end else begin
            bus.smm_in_valid_size <= size_nx;
            bus.smm_in_valid_a    <= a_nx;
            bus.smm_in_valid_b    <= b_nx;
            if (size_nx) bus.smm_in_size <= bus.req_size[sel];
            if (a_nx) begin
                bus.smm_in_row_a <= bus.req_row[sel];
                bus.smm_in_col_a <= bus.req_col[sel];
                bus.smm_in_val_a <= bus.req_val[sel];
            end
            if (b_nx) begin
                bus.smm_in_row_b <= bus.req_row[sel];
                bus.smm_in_col_b <= bus.req_col[sel];
                bus.smm_in_val_b <= bus.req_val[sel];
            end
            bus.rsp_valid <= (state == ST_WAIT && bus.smm_out_valid) ? onehot2(owner) : 2'b00;
            if (state == ST_WAIT && bus.smm_out_valid) begin
                bus.rsp_row <= bus.smm_out_row;
                bus.rsp_col <= bus.smm_out_col;
                bus.rsp_val <= bus.smm_out_val;
            end
            bus.rsp_done <= done ? onehot2(owner) : 2'b00;
            bus.err      <= err_nx;
        end
    end

endmodule

// File: tb/tb_smm_sched.sv
// tb_smm_sched: directed + randomized bench for smm_sched. Expected SMM beats,
// error pulses, results and completions are built as timestamped event lists
// from the job descriptions and compared against what a negedge monitor sees.
module tb_smm_sched;
    import smm_sched_pkg::*;

    localparam int TIMEOUT = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    smm_sched_if bus();

    smm_sched #(.TIMEOUT(TIMEOUT), .TCNT_W(13)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [1:0]  k;
        logic [31:0] cyc;
        logic [18:0] d;
    } ev_t;
    typedef ev_t evq_t[$];

    evq_t exp_in, obs_in, exp_err, obs_err, exp_rsp, obs_rsp, exp_done, obs_done;
    int checks = 0, failures = 0;
    int cyc = 0;
    bit in_wait = 1'b0;
    int viol_onehot = 0, viol_rdy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.smm_in_valid_size) obs_in.push_back('{2'd0, cyc, {18'd0, bus.smm_in_size}});
            if (bus.smm_in_valid_a)
                obs_in.push_back('{2'd1, cyc, {5'd0, bus.smm_in_row_a, bus.smm_in_col_a, bus.smm_in_val_a}});
            if (bus.smm_in_valid_b)
                obs_in.push_back('{2'd2, cyc, {5'd0, bus.smm_in_row_b, bus.smm_in_col_b, bus.smm_in_val_b}});
            if ($countones({bus.smm_in_valid_size, bus.smm_in_valid_a, bus.smm_in_valid_b}) > 1)
                viol_onehot <= viol_onehot + 1;
            if (bus.rsp_valid != 2'b00)
                obs_rsp.push_back('{bus.rsp_valid, cyc, {bus.rsp_row, bus.rsp_col, bus.rsp_val}});
            if (bus.err != 2'b00)      obs_err.push_back('{bus.err, cyc, 19'd0});
            if (bus.rsp_done != 2'b00) obs_done.push_back('{bus.rsp_done, cyc, 19'd0});
            // While a job is held only its owner may be ready, and nobody in WAIT.
            if (bus.busy && (((bus.req_ready & ~onehot2(bus.owner)) != 2'b00) ||
                             (in_wait && bus.req_ready != 2'b00)))
                viol_rdy <= viol_rdy + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_q(input string tag, input evq_t e, input evq_t o);
        check({tag, "_count"}, o.size(), e.size());
        for (int i = 0; i < e.size() && i < o.size(); i++)
            check($sformatf("%s[%0d]", tag, i), o[i], e[i]);
    endtask

    task automatic clear_q();
        exp_in.delete();  obs_in.delete();
        exp_err.delete(); obs_err.delete();
        exp_rsp.delete(); obs_rsp.delete();
        exp_done.delete(); obs_done.delete();
    endtask

    task automatic cmp_all();
        cmp_q("smm_in", exp_in, obs_in);
        cmp_q("err", exp_err, obs_err);
        cmp_q("rsp", exp_rsp, obs_rsp);
        cmp_q("done", exp_done, obs_done);
        clear_q();
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0; bus.req_kind = '0; bus.req_last = '0; bus.req_size = '0;
        bus.req_row = '0;   bus.req_col = '0;  bus.req_val = '0;
        bus.smm_out_valid = 1'b0; bus.smm_out_row = '0; bus.smm_out_col = '0; bus.smm_out_val = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        in_wait = 1'b0;
        clear_q();
    endtask

    // One requester beat; expk: 0 size, 1 A, 2 B forwarded, 3 dropped with err.
    // Must be entered 1 time unit after a rising edge.
    task automatic beat(input int r, input logic [1:0] k, input logic last, input logic sz,
                        input logic [4:0] row, input logic [4:0] col, input logic [3:0] v,
                        input int expk);
        int n = 0;
        bus.req_valid[r] = 1'b1; bus.req_kind[r] = k;   bus.req_last[r] = last;
        bus.req_size[r]  = sz;   bus.req_row[r]  = row; bus.req_col[r]  = col; bus.req_val[r] = v;
        @(negedge clk);
        while (!bus.req_ready[r] && n < 64) begin @(negedge clk); n++; end
        check("hs_wait", n < 64, 1);
        @(posedge clk); #1;
        bus.req_valid[r] = 1'b0;
        case (expk)
            0:       exp_in.push_back('{2'd0, cyc, {18'd0, sz}});
            1:       exp_in.push_back('{2'd1, cyc, {5'd0, row, col, v}});
            2:       exp_in.push_back('{2'd2, cyc, {5'd0, row, col, v}});
            default: exp_err.push_back('{onehot2(r[0]), cyc, 19'd0});
        endcase
    endtask

    task automatic bubble();
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    endtask

    // Entered right after the last-B handshake. d idle cycles, then n_out
    // back-to-back results (first one = d0); n_out = 0 means timeout.
    task automatic run_wait(input int r, input int d, input int n_out,
                            input logic [18:0] d0, input logic [1:0] rdy_done);
        int n = 0;
        logic [18:0] dv;
        in_wait = 1'b1;
        if (n_out == 0) exp_done.push_back('{onehot2(r[0]), cyc + TIMEOUT, 19'd0});
        repeat (d) begin @(posedge clk); #1; end
        for (int j = 0; j < n_out; j++) begin
            dv = (j == 0) ? d0 : 19'($urandom);
            bus.smm_out_valid = 1'b1;
            {bus.smm_out_row, bus.smm_out_col, bus.smm_out_val} = dv;
            exp_rsp.push_back('{onehot2(r[0]), cyc + 1, dv});
            @(posedge clk); #1;
        end
        bus.smm_out_valid = 1'b0;
        if (n_out > 0) exp_done.push_back('{onehot2(r[0]), cyc + 1, 19'd0});
        @(negedge clk);
        while (bus.rsp_done == 2'b00 && n < TIMEOUT + 64) begin @(negedge clk); n++; end
        check("done_wait", n < TIMEOUT + 64, 1);
        in_wait = 1'b0;
        check("done_busy", bus.busy, 0);
        check("done_rdy", bus.req_ready, rdy_done);
        #1 cmp_all();
        @(posedge clk); #1;
    endtask

    task automatic run_job(input int r, input int n_a, input int n_b, input bit junk_idle,
                           input bit a_after_b, input bit junk_load, input int d, input int n_out);
        if (junk_idle) beat(r, 2'($urandom_range(1, 3)), 1'b0, 1'b0, 5'($urandom), 5'($urandom), 4'($urandom), 3);
        beat(r, KIND_SIZE, 1'b0, 1'($urandom), 5'd0, 5'd0, 4'd0, 0);
        for (int i = 0; i < n_a; i++) begin
            bubble();
            beat(r, KIND_A, 1'b0, 1'b0, 5'($urandom), 5'($urandom), 4'($urandom), 1);
        end
        if (junk_load) beat(r, ($urandom_range(0, 1) != 0) ? 2'd0 : 2'd3, 1'b0, 1'b0, 5'd1, 5'd2, 4'd3, 3);
        for (int i = 0; i < n_b; i++) begin
            bubble();
            beat(r, KIND_B, (i == n_b - 1), 1'b0, 5'($urandom), 5'($urandom), 4'($urandom), 2);
            if (a_after_b && i == 0 && n_b > 1)
                beat(r, KIND_A, 1'b0, 1'b0, 5'($urandom), 5'($urandom), 4'($urandom), 3);
        end
        run_wait(r, d, n_out, 19'($urandom), 2'b00);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_owner", bus.owner, 0);
        check("rst_ready", bus.req_ready, 0);
        check("rst_smm_valids", {bus.smm_in_valid_size, bus.smm_in_valid_a, bus.smm_in_valid_b}, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_done", bus.rsp_done, 0);
        check("rst_err", bus.err, 0);
        check("rst_rsp_data", {bus.rsp_row, bus.rsp_col, bus.rsp_val}, 0);
        @(posedge clk); #1 rst = 1'b0;
        clear_q();

        // Single job from req0 with one fixed result (3,7,10).
        beat(0, KIND_SIZE, 1'b0, 1'b1, 5'd0, 5'd0, 4'd0, 0);
        beat(0, KIND_A,    1'b0, 1'b0, 5'd3, 5'd4, 4'd5, 1);
        beat(0, KIND_B,    1'b1, 1'b0, 5'd4, 5'd7, 4'd2, 2);
        run_wait(0, 0, 1, {5'd3, 5'd7, 9'd10}, 2'b00);

        // Both requesters present SIZE together after reset: req0 first.
        do_reset();
        bus.req_valid = 2'b11; bus.req_kind = '0; bus.req_size = 2'b10;
        @(negedge clk);
        check("both_ready", bus.req_ready, 2'b01);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        exp_in.push_back('{2'd0, cyc, 19'd0});
        beat(0, KIND_A, 1'b0, 1'b0, 5'd1, 5'd2, 4'd9, 1);
        beat(0, KIND_B, 1'b1, 1'b0, 5'd2, 5'd3, 4'd4, 2);
        run_wait(0, 1, 1, {5'd1, 5'd3, 9'd36}, 2'b10);
        // req1's SIZE was accepted in the rsp_done[0] cycle.
        exp_in.push_back('{2'd0, cyc, 19'd1});
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        check("owner1", bus.owner, 1);
        check("busy1", bus.busy, 1);
        @(posedge clk); #1;
        beat(1, KIND_A, 1'b0, 1'b0, 5'd6, 5'd6, 4'd1, 1);
        beat(1, KIND_B, 1'b1, 1'b0, 5'd6, 5'd8, 4'd7, 2);
        run_wait(1, 0, 0, 19'd0, 2'b00);

        // A after B inside a job from req0 is dropped, job still completes.
        run_job(0, 2, 2, 1'b0, 1'b1, 1'b0, 0, 2);
        // Junk beat while idle, then junk SIZE/reserved beat during load.
        run_job(1, 1, 1, 1'b1, 1'b0, 1'b1, 2, 1);

        // Randomized jobs.
        for (int j = 0; j < 12; j++)
            run_job($urandom_range(0, 1), $urandom_range(1, 3), $urandom_range(1, 3),
                    1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(1, 3));

        // Reset in WAIT with a result in flight.
        beat(0, KIND_SIZE, 1'b0, 1'b0, 5'd0, 5'd0, 4'd0, 0);
        beat(0, KIND_A,    1'b0, 1'b0, 5'd5, 5'd5, 4'd5, 1);
        beat(0, KIND_B,    1'b1, 1'b0, 5'd5, 5'd9, 4'd3, 2);
        in_wait = 1'b1;
        bus.smm_out_valid = 1'b1;
        {bus.smm_out_row, bus.smm_out_col, bus.smm_out_val} = {5'd5, 5'd9, 9'd15};
        @(posedge clk); #1;
        bus.smm_out_valid = 1'b0;
        cmp_q("rstw_smm_in", exp_in, obs_in);
        #2 rst = 1'b1;
        @(negedge clk);
        check("rstw_busy", bus.busy, 0);
        check("rstw_owner", bus.owner, 0);
        check("rstw_rsp_valid", bus.rsp_valid, 0);
        check("rstw_rsp_data", {bus.rsp_row, bus.rsp_col, bus.rsp_val}, 0);
        check("rstw_rsp_done", bus.rsp_done, 0);
        check("rstw_smm", {bus.smm_in_valid_size, bus.smm_in_valid_a, bus.smm_in_valid_b,
                           bus.smm_in_row_b, bus.smm_in_col_b, bus.smm_in_val_b}, 0);
        @(posedge clk); #1 rst = 1'b0;
        in_wait = 1'b0;
        clear_q();
        run_job(1, 2, 2, 1'b0, 1'b0, 1'b0, 1, 2);

        check("no_done_after_rst_cnt", obs_done.size(), 0);
        check("smm_in_onehot", viol_onehot, 0);
        check("ready_rules", viol_rdy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
